// File: rtl/uart_tx_fifo_p.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_p
// Purpose  : UART transmit buffer: circular FIFO feeding a start/data/parity/
//            stop serialiser clocked at one bit per baud_clk.
// Option   : UART_TX_PARITY_EN compiles in the runtime-selectable parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int STOP_BITS = 1
) (
    input  logic              baud_clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        parity_mode,
    input  logic              tx_enable,
    input  logic              rx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int                 c_CNT_W     = $clog2(DATA_W);
    localparam logic [ADDR_W:0]    c_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(STOP_BITS - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd4;
`endif

    logic [DATA_W-1:0]  r_mem [0:2**ADDR_W-1];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               w_launch_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_tx_bit;
    logic               w_busy;
    logic [ADDR_W:0]    w_count_next;

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_bit;
`else
    logic w_unused_parity;
    assign w_unused_parity = ^parity_mode;
`endif

    assign w_launch_ok = tx_enable && rx_ready && !empty;
    assign w_push      = wr_en && !full;
    // A pop happens from IDLE or on the final stop bit, giving gap-free streaming.
    assign w_pop       = w_launch_ok &&
                         ((r_state == c_S_IDLE) ||
                          ((r_state == c_S_STOP) && (r_bit_cnt == c_STOP_LAST)));

    always_comb begin
        w_count_next = count;
        if (w_push && !w_pop) begin
            w_count_next = count + (ADDR_W+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = count - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge baud_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (w_launch_ok) w_state_next = c_S_START;
            c_S_START: w_state_next = c_S_DATA;
            c_S_DATA: begin
                if (r_bit_cnt == c_DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = r_par_en ? c_S_PARITY : c_S_STOP;
`else
                    w_state_next = c_S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            c_S_PARITY: w_state_next = c_S_STOP;
`endif
            c_S_STOP: begin
                if (r_bit_cnt == c_STOP_LAST) begin
                    w_state_next = w_launch_ok ? c_S_START : c_S_IDLE;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_bit = 1'b1;
        w_busy   = (r_state != c_S_IDLE);
        case (r_state)
            c_S_START:  w_tx_bit = 1'b0;
            c_S_DATA:   w_tx_bit = r_shift[0];
`ifdef UART_TX_PARITY_EN
            c_S_PARITY: w_tx_bit = r_par_bit;
`endif
            default:    w_tx_bit = 1'b1;
        endcase
    end

    // Line and status outputs are registered one cycle behind the state.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            tx_out    <= 1'b1;
            tx_busy   <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
            count     <= '0;
            overflow  <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            tx_out   <= w_tx_bit;
            tx_busy  <= w_busy;
            overflow <= wr_en && full;
            count    <= w_count_next;
            full     <= (w_count_next == c_DEPTH);
            empty    <= (w_count_next == '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                r_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                r_par_bit <= (^r_mem[r_rd_ptr]) ^ (parity_mode == 2'b10);
`endif
            end else if (r_state == c_S_DATA) begin
                r_shift <= r_shift >> 1;
            end
            if (w_state_next != r_state) begin
                r_bit_cnt <= '0;
            end else if ((r_state == c_S_DATA) || (r_state == c_S_STOP)) begin
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo_p.md
# uart_tx_fifo_p

Parametrised UART transmit buffer. It accepts parallel words from the host into a circular FIFO and serialises them one bit per `baud_clk`: start bit, LSB-first data, optional parity bit, then stop bit(s). This block is the next-generation transmit front end of the UART_FIFO link and feeds the receive FIFO's serial input. Relative to the first-generation transmitter, it adds configurable width, depth and stop bits, runtime parity selection, an occupancy count, overflow reporting and gap-free back-to-back frames.

## Interface
- `DATA_W`, 8, data bits per frame (5..9)
- `ADDR_W`, 4, FIFO address width; depth = 2**`ADDR_W`
- `STOP_BITS`, 1, stop bits per frame (1 or 2)
- `baud_clk` in 1: bit clock, rising edge; one cycle = one bit time
- `rst` in 1: asynchronous, active-high reset
- `wr_en` in 1: write request
- `wr_data` in `DATA_W`: word to enqueue
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none
- `tx_enable` in 1: permits launching new frames
- `rx_ready` in 1: far-end receiver ready for a new frame
- `tx_out` out 1: serial line, idle high
- `tx_busy` out 1: frame in progress (state != IDLE)
- `full` out 1: count == 2**`ADDR_W`
- `empty` out 1: count == 0
- `count` out `ADDR_W`+1: occupancy
- `overflow` out 1: one-cycle pulse on a dropped write

## Operation
- **Storage.** Array of 2**`ADDR_W` x `DATA_W`.
  - Pointers `wr_ptr` and `rd_ptr` are `ADDR_W` bits and wrap naturally.
  - `count` is tracked separately; `full` and `empty` are decoded from `count` and registered.
- **Write.** On `wr_en && !full`: store at `wr_ptr`, increment `wr_ptr`.
  - On `wr_en && full`: the word is dropped and `overflow` = 1 for the next cycle.
  - `full` is sampled pre-edge, so a write to a full FIFO is dropped even if a pop happens in the same cycle.
- **Launch condition** L = `tx_enable && rx_ready && !empty`.
  - At launch: head word → shift register, `parity_mode` latched, `rd_ptr`++.
  - Write and pop in the same cycle leave `count` unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx_out` = 1. If L, go to START.
  - START: `tx_out` = 0 for 1 cycle, then DATA.
  - DATA: `DATA_W` cycles, LSB first; bit counter = clog2(`DATA_W`) bits, no wrap.
    - Next state is PARITY if the latched mode is 01/10, else STOP.
  - PARITY: 1 cycle. Even = XOR of data bits; odd = its inverse.
  - STOP: `tx_out` = 1 for `STOP_BITS` cycles.
    - On the last stop cycle: if L, pop and go directly to START (no idle gap); else go to IDLE.
- **Mid-frame input changes.** `tx_enable`, `rx_ready` and `parity_mode` changes mid-frame do not affect the current frame. The frame always completes.
- **Reset** (async, at any time):
  - `tx_out` = 1, `tx_busy` = 0, `full` = 0, `empty` = 1, `count` = 0, `overflow` = 0.
  - Pointers = 0, state = IDLE.
  - The in-flight frame and all FIFO contents are discarded.

## Timing
- All outputs are registered; `tx_out` is glitch-free.
- Write-to-flag latency: `count`, `full` and `empty` update on the edge that accepts the write.
- Launch latency:
  - Launch evaluated at edge N → `tx_out` = 0 after edge N+1.
  - A word written at edge N into an empty idle FIFO launches at N+1 and its start bit appears after N+2.
- Frame length = 1 + `DATA_W` + P + `STOP_BITS` cycles, where P ∈ {0, 1}.
- Streaming: back-to-back frames are contiguous while L holds.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state, parity generator and `parity_mode` latch are compiled in, with behaviour as above.
- Undefined:
  - `parity_mode` is ignored; the PARITY state and parity logic are absent.
  - DATA always proceeds to STOP; frame = 1 + `DATA_W` + `STOP_BITS`.

## Test plan
All scenarios use defaults unless stated.
- **Even parity:** write 0xA5, mode 01, `tx_enable` = `rx_ready` = 1 → `tx_out` = 0,1,0,1,0,0,1,0,1,0,1, then idle 1; `count` 1→0; `tx_busy` high for 11 cycles.
- **Odd parity:** same as above with mode 10 → parity bit 1.
  - Without `UART_TX_PARITY_EN`: 10-bit frame, no parity bit.
- **Full / overflow:** 16 writes with `tx_enable` = 0 → `full` = 1, `count` = 16. A 17th write → `overflow` pulse, `count` stays 16. Draining then yields the first 16 words in order.
- **Back-to-back, wrap, flow control:**
  - Write 0x01, 0x02 with `STOP_BITS` = 2 and mode 00 → two contiguous 11-cycle frames, no idle gap.
  - Interleave 40 writes and reads → pointers wrap, data order preserved.
  - `rx_ready` = 0 → stays IDLE with `tx_out` = 1.
- **Reset mid-frame:** assert `rst` during the DATA bit 3 cycle with `count` = 5 → `tx_out` = 1, `count` = 0, `empty` = 1 immediately. After release, no frame is emitted.
